// File: rtl/elevator_pkg.sv
// Shared elevator types and constants used by the car motion block and its timer.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int TOP_FLOOR  = 7;

  typedef logic [2:0] floor_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    ARRIVE,
    DOOR_OPEN
  } car_state_t;

  // A move is legal unless it would leave the shaft at either end.
  function automatic logic move_legal(input floor_t floor, input logic dir);
    if (dir == DIR_UP) begin
      return floor != floor_t'(TOP_FLOOR);
    end
    return floor != floor_t'(0);
  endfunction

endpackage

// File: rtl/car_motion_cycle_timer.sv
// cycle_timer: 8-bit loadable down-counter that saturates at zero.
module cycle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/car_motion.sv
// car_motion: elevator car FSM stepping between floors and cycling the door.
// Define CAR_MOTION_DOOR_HOLD_EN to add the door_hold input.
module car_motion
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       should_move,
  input  logic       direction,
  input  logic [7:0] call_all,
`ifdef CAR_MOTION_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [2:0] cur_floor,
  output logic       floor_reached,
  output logic       moving,
  output logic       door_open
);

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  car_state_t state, state_next;
  floor_t     floor_next;
  logic       dir_q, dir_next;
  logic       t_load, t_dec, t_zero, enter_door;
  logic [7:0] t_value;

  cycle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (t_load),
    .load_value (t_value),
    .dec        (t_dec),
    .zero       (t_zero)
  );

  always_comb begin
    state_next = state;
    floor_next = cur_floor;
    dir_next   = dir_q;
    t_load     = 1'b0;
    t_value    = TRAVEL_LOAD;
    t_dec      = 1'b0;
    enter_door = 1'b0;
    case (state)
      IDLE: begin
        if (call_all[cur_floor]) begin
          state_next = DOOR_OPEN;
          t_load     = 1'b1;
          t_value    = DOOR_LOAD;
          enter_door = 1'b1;
        end else if (should_move && move_legal(cur_floor, direction)) begin
          state_next = MOVING;
          dir_next   = direction;
          t_load     = 1'b1;
        end
      end
      MOVING: begin
        // Inputs are deliberately ignored here; the car never stops mid-shaft.
        if (t_zero) begin
          floor_next = (dir_q == DIR_UP) ? cur_floor + 3'd1 : cur_floor - 3'd1;
          state_next = ARRIVE;
        end else begin
          t_dec = 1'b1;
        end
      end
      ARRIVE: begin
        if (call_all[cur_floor]) begin
          state_next = DOOR_OPEN;
          t_load     = 1'b1;
          t_value    = DOOR_LOAD;
          enter_door = 1'b1;
        end else if (should_move && (direction == dir_q) && move_legal(cur_floor, dir_q)) begin
          state_next = MOVING;
          t_load     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      DOOR_OPEN: begin
`ifdef CAR_MOTION_DOOR_HOLD_EN
        if (door_hold) begin
          t_load  = 1'b1;
          t_value = DOOR_LOAD;
        end else
`endif
        if (t_zero) begin
          state_next = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cur_floor     <= 3'd0;
      dir_q         <= DIR_UP;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      floor_reached <= 1'b0;
    end else begin
      state         <= state_next;
      cur_floor     <= floor_next;
      dir_q         <= dir_next;
      moving        <= (state_next == MOVING);
      door_open     <= (state_next == DOOR_OPEN);
      floor_reached <= enter_door;
    end
  end

endmodule

// File: tb/tb_car_motion.sv
// Scoreboard bench for car_motion: an activity-level model predicts every cycle's outputs.
module tb_car_motion;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_ARR = 2, M_DOOR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       should_move = 1'b0;
  logic       direction = 1'b1;
  logic [7:0] call_all = 8'h00;
  logic       door_hold = 1'b0;
  logic [2:0] cur_floor;
  logic       floor_reached, moving, door_open;

  typedef struct packed {
    logic [2:0] fl;
    logic       mv;
    logic       dr;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // model state: activity, cycles left in it (including the current one), floor, direction
  int   m_state = M_IDLE;
  int   m_rem = 0;
  int   m_floor = 0;
  bit   m_dir = 1'b1;
  bit   m_pulse = 1'b0;

  car_motion #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk           (clk),
    .reset         (reset),
    .should_move   (should_move),
    .direction     (direction),
    .call_all      (call_all),
`ifdef CAR_MOTION_DOOR_HOLD_EN
    .door_hold     (door_hold),
`endif
    .cur_floor     (cur_floor),
    .floor_reached (floor_reached),
    .moving        (moving),
    .door_open     (door_open)
  );

  always #5 clk = ~clk;

  function automatic bit can_go(int f, bit d);
    return d ? (f < 7) : (f > 0);
  endfunction

  function automatic bit hold_active();
`ifdef CAR_MOTION_DOOR_HOLD_EN
    return door_hold;
`else
    return 1'b0;
`endif
  endfunction

  // reference model, one step per rising edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_pulse = 1'b0;
      if (reset) begin
        m_state = M_IDLE; m_floor = 0; m_dir = 1'b1; m_rem = 0;
      end else begin
        case (m_state)
          M_IDLE: begin
            if (call_all[m_floor]) begin
              m_state = M_DOOR; m_rem = DOOR; m_pulse = 1'b1;
            end else if (should_move && can_go(m_floor, direction)) begin
              m_state = M_MOVE; m_rem = TRAVEL; m_dir = direction;
            end
          end
          M_MOVE: begin
            m_rem--;
            if (m_rem == 0) begin
              m_floor = m_dir ? m_floor + 1 : m_floor - 1;
              m_state = M_ARR;
            end
          end
          M_ARR: begin
            if (call_all[m_floor]) begin
              m_state = M_DOOR; m_rem = DOOR; m_pulse = 1'b1;
            end else if (should_move && direction == m_dir && can_go(m_floor, m_dir)) begin
              m_state = M_MOVE; m_rem = TRAVEL;
            end else begin
              m_state = M_IDLE;
            end
          end
          default: begin
            if (hold_active()) begin
              m_rem = DOOR;
            end else begin
              m_rem--;
              if (m_rem == 0) m_state = M_IDLE;
            end
          end
        endcase
      end
      exp_q.push_back('{fl: 3'(m_floor), mv: (m_state == M_MOVE),
                        dr: (m_state == M_DOOR), fr: m_pulse});
    end
  end

  // monitor: compare DUT outputs with the oldest prediction on each falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({cur_floor, moving, door_open, floor_reached} != e) begin
          errors++;
          $display("FAIL outputs cyc %0d floor/moving/door/reached got %0d/%b/%b/%b want %0d/%b/%b/%b",
                   cyc, cur_floor, moving, door_open, floor_reached, e.fl, e.mv, e.dr, e.fr);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({cur_floor, moving, door_open, floor_reached} != 6'd0) begin
      errors++;
      $display("FAIL %s floor/moving/door/reached got %0d/%b/%b/%b want 0/0/0/0",
               tag, cur_floor, moving, door_open, floor_reached);
    end
  endtask

  // assert reset between edges and verify it acts without waiting for a clock
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero_outputs(tag);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_model(input int fl, input int st, input int limit, input string tag);
    int n = 0;
    while (!(m_floor == fl && m_state == st) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s timeout got floor %0d state %0d want floor %0d state %0d", tag, m_floor, m_state, fl, st);
    end
  endtask

  task automatic check_floor(input string tag, input logic [2:0] want, input logic want_mv);
    checks++;
    if (cur_floor != want || moving != want_mv) begin
      errors++;
      $display("FAIL %s floor/moving got %0d/%b want %0d/%b", tag, cur_floor, moving, want, want_mv);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    #2 reset = 1'b0;

    // service the call at floor 0
    call_all = 8'h01;
    @(negedge clk);
    call_all = 8'h00;
    repeat (5) @(negedge clk);

    // ride up to a call at floor 3
    should_move = 1'b1; direction = 1'b1; call_all = 8'h08;
    wait_model(3, M_DOOR, 40, "reach_floor3");
    call_all = 8'h00; should_move = 1'b0;
    repeat (5) @(negedge clk);

    // top boundary: request up at floor 7 is refused
    should_move = 1'b1; direction = 1'b1;
    wait_model(7, M_IDLE, 60, "reach_top");
    repeat (10) @(negedge clk);
    check_floor("stay_top", 3'd7, 1'b0);

    // come down to floor 2 and stop
    direction = 1'b0;
    wait_model(2, M_ARR, 60, "reach_floor2");
    should_move = 1'b0;
    repeat (3) @(negedge clk);

    // direction flip mid-travel is ignored until ARRIVE
    should_move = 1'b1; direction = 1'b1;
    wait_model(2, M_MOVE, 5, "start_up");
    repeat (2) @(negedge clk);
    direction = 1'b0;
    wait_model(3, M_ARR, 10, "flip_arrive");
    check_floor("flip_floor3", 3'd3, 1'b0);
    should_move = 1'b0;
    repeat (4) @(negedge clk);

    // reset in the second door cycle at floor 5
    should_move = 1'b1; direction = 1'b1; call_all = 8'h20;
    wait_model(5, M_DOOR, 60, "reach_floor5");
    call_all = 8'h00; should_move = 1'b0;
    @(negedge clk);
    pulse_reset("reset_in_door");
    repeat (10) @(negedge clk);

`ifdef CAR_MOTION_DOOR_HOLD_EN
    begin
      int opens = 0;
      int pulses = 0;
      door_hold = 1'b1; call_all = 8'h01;
      wait_model(0, M_DOOR, 5, "hold_enter");
      call_all = 8'h00;
      for (int i = 1; i <= 20; i++) begin
        opens += door_open;
        pulses += floor_reached;
        if (i == 11) door_hold = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (opens != 13 || pulses != 1) begin
        errors++;
        $display("FAIL door_hold open/pulses got %0d/%0d want 13/1", opens, pulses);
      end
    end
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      should_move = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) direction = ~direction;
      if ($urandom % 5 == 0) call_all = 8'($urandom & $urandom & $urandom);
      door_hold = ($urandom % 6) == 0;
      if ($urandom % 250 == 0) pulse_reset("random_reset");
      else @(negedge clk);
    end

    should_move = 1'b0; call_all = 8'h00; door_hold = 1'b0;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
